// File: rtl/spi_master_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM encodings, mode constants
// and default sizing used by the master and its clock divider.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int SPI_CPOL        = 0;
  localparam int SPI_CPHA        = 0;
  localparam int DEFAULT_DATA_W  = 8;
  localparam int DEFAULT_CLK_DIV = 4;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: counts CLK_DIV system clocks while enabled and strobes
// phase_end on the last cycle of every half-period.
module spi_clk_div
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_l,
  input  logic i_en,
  output logic o_phase_end
);

  localparam int CNT_W = min1_clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_phase_end = i_en && (r_cnt == LAST_CNT);

  // Divider counter, parked at zero while the master is idle.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_cnt <= '0;
    end else if (!i_en || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master, MSB first, one full-duplex word per
// accepted start; every SPI pin and status output comes straight from a flop.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ss_l,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = min1_clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic [BIT_W-1:0]  r_bit;
  logic              r_ss_l;
  logic              r_sclk;
  logic              r_mosi;
  logic              r_busy;
  logic              r_done;

  logic              w_clk_en;
  logic              w_phase_end;
  logic              w_last_bit;

  assign w_clk_en   = (r_state != ST_IDLE);
  assign w_last_bit = (r_bit == LAST_BIT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk       (clk),
    .i_rst_l     (rst_l),
    .i_en        (w_clk_en),
    .o_phase_end (w_phase_end)
  );

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic              b);
    return {cur[DATA_W-2:0], b};
  endfunction

  // Frame sequencer. A start seen on the last GAP cycle chains straight into
  // LEAD so back-to-back frames keep ss_l high for exactly one half-period.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= ST_IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_bit      <= '0;
      r_ss_l     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tx_shift <= tx_data;
            r_mosi     <= tx_data[DATA_W-1];
            r_ss_l     <= 1'b0;
            r_busy     <= 1'b1;
            r_bit      <= '0;
            r_state    <= ST_LEAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LEAD: begin
          if (w_phase_end) begin
            r_sclk     <= 1'b1;
            r_rx_shift <= shift_in(r_rx_shift, miso);
            r_state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_phase_end) begin
            r_sclk  <= 1'b0;
            r_state <= ST_LOW;
            if (!w_last_bit) begin
              r_mosi     <= r_tx_shift[DATA_W-2];
              r_tx_shift <= r_tx_shift << 1;
            end
          end
        end
        ST_LOW: begin
          if (w_phase_end) begin
            if (!w_last_bit) begin
              r_bit      <= r_bit + BIT_W'(1);
              r_sclk     <= 1'b1;
              r_rx_shift <= shift_in(r_rx_shift, miso);
              r_state    <= ST_HIGH;
            end else begin
              r_ss_l    <= 1'b1;
              r_mosi    <= 1'b0;
              r_rx_data <= r_rx_shift;
              r_done    <= 1'b1;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (w_phase_end) begin
            if (start) begin
              r_tx_shift <= tx_data;
              r_mosi     <= tx_data[DATA_W-1];
              r_ss_l     <= 1'b0;
              r_bit      <= '0;
              r_state    <= ST_LEAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ss_l  <= 1'b1;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign ss_l    = r_ss_l;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;

endmodule
